aim65_bus_ctrl: RTL and testbench

//  Parametrised AIM-65 system bus controller. Replaces the flat decoder/mux.
//  - Decodes the CPU address into chip selects.
//  - Returns read data from a registered select that matches the 1-cycle synchronous RAM/ROM read.
//  - Inserts programmable wait states on the I/O page.
//  - Switches Z25/Z26 extension ROM images at run time, glitch-free, on opcode-fetch boundaries.

---
 rtl/aim65_pkg.sv | 25 ++
 rtl/aim65_ws_fsm.sv | 79 +++++++
 rtl/aim65_bus_ctrl.sv | 165 ++++++++++++++++
 tb/tb_aim65_bus_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/aim65_pkg.sv
// Shared definitions for the AIM-65 bus controller: address regions and page numbers.
package aim65_pkg;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_IO,
    REG_Z22,
    REG_Z23,
    REG_Z24,
    REG_Z25,
    REG_Z26,
    REG_NONE
  } region_e;

  // Upper address nibble of each fixed 4K page
  localparam logic [3:0] PAGE_IO  = 4'hA;
  localparam logic [3:0] PAGE_Z26 = 4'hB;
  localparam logic [3:0] PAGE_Z25 = 4'hC;
  localparam logic [3:0] PAGE_Z24 = 4'hD;
  localparam logic [3:0] PAGE_Z23 = 4'hE;
  localparam logic [3:0] PAGE_Z22 = 4'hF;

  localparam int IO_WAIT_MAX = 15;

endpackage

// File: rtl/aim65_ws_fsm.sv
// I/O wait-state generator: holds rdy low for IO_WAIT cycles per new I/O access.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | rdy high unless a fresh I/O access starts this cycle
//  S_WAIT | counting down; rdy goes high on the cycle the count reaches 0
module aim65_ws_fsm
  import aim65_pkg::*;
#(
  parameter int IO_WAIT = 0
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        io_acc,
  input  logic [15:0] addr,
  output logic        rdy
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam int         WAIT_CLAMP = (IO_WAIT > IO_WAIT_MAX) ? IO_WAIT_MAX : IO_WAIT;
  localparam logic [3:0] LOAD       = (WAIT_CLAMP > 0) ? 4'(WAIT_CLAMP - 1) : 4'd0;
  localparam logic       WAIT_EN    = (WAIT_CLAMP > 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        hold_q, hold_d;
  logic [15:0] hold_addr_q, hold_addr_d;
  logic        rdy_fsm;

  // State, countdown and "already waited on this address" tracking
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      hold_q      <= 1'b0;
      hold_addr_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  // Next state; an address the CPU keeps driving after its wait completed is not re-waited
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_addr_d = hold_addr_q;
    rdy_fsm     = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!io_acc || (addr != hold_addr_q)) hold_d = 1'b0;
        if (io_acc && WAIT_EN && !(hold_q && (addr == hold_addr_q))) begin
          rdy_fsm = 1'b0;
          cnt_d   = LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_IDLE;
          hold_d      = 1'b1;
          hold_addr_d = addr;
        end else begin
          rdy_fsm = 1'b0;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset must release the CPU immediately, even while an I/O address is on the bus
  assign rdy = rdy_fsm | reset;

endmodule

// File: rtl/aim65_bus_ctrl.sv
// AIM-65 system bus controller: address decode, registered read mux,
// I/O wait states and run-time extension ROM image switching.
module aim65_bus_ctrl
  import aim65_pkg::*;
#(
  parameter int         RAM_AW     = 15,
  parameter int         NUM_IMAGES = 3,
  parameter int         SEL_W      = 2,
  parameter int         IO_WAIT    = 0,
  parameter logic [7:0] OPEN_BUS   = 8'hFF
) (
  input  logic                    cpu_clk,
  input  logic                    reset,
  input  logic [15:0]             addr,
  input  logic                    rw,
  input  logic                    sync,
  input  logic [SEL_W-1:0]        ext_selector,
  input  logic [7:0]              ram_do,
  input  logic [7:0]              z22_do,
  input  logic [7:0]              z23_do,
  input  logic [7:0]              z24_do,
  input  logic [8*NUM_IMAGES-1:0] z25_do,
  input  logic [8*NUM_IMAGES-1:0] z26_do,
  input  logic [31:0]             io_do,
  output logic                    ram_cs,
  output logic                    z22_cs,
  output logic                    z23_cs,
  output logic                    z24_cs,
  output logic                    z25_cs,
  output logic                    z26_cs,
  output logic [3:0]              io_cs,
  output logic [7:0]              cpu_data,
  output logic                    rdy,
  output logic [SEL_W-1:0]        ext_active,
  output logic                    unmapped
);

  localparam logic [SEL_W:0] NUM_IMG_W = (SEL_W + 1)'(NUM_IMAGES);

  region_e          region;
  region_e          sel_q, sel_d;
  logic [1:0]       iopg_q, iopg_d;
  logic [SEL_W-1:0] img_q, img_d;
  logic [SEL_W-1:0] sync_s1_q, sync_s1_d;
  logic [SEL_W-1:0] sync_s2_q, sync_s2_d;
  logic [SEL_W-1:0] ext_active_q, ext_active_d;
  logic             unmapped_q, unmapped_d;
  logic             in_socket;
  logic             req_ok;

  // Address decode; RAM has priority so a small RAM_AW just leaves a hole below Axxx
  always_comb begin
    region = REG_NONE;
    if ((addr >> RAM_AW) == 16'd0) begin
      region = REG_RAM;
    end else begin
      case (addr[15:12])
        PAGE_IO:  region = REG_IO;
        PAGE_Z26: region = REG_Z26;
        PAGE_Z25: region = REG_Z25;
        PAGE_Z24: region = REG_Z24;
        PAGE_Z23: region = REG_Z23;
        PAGE_Z22: region = REG_Z22;
        default:  region = REG_NONE;
      endcase
    end
  end

  assign ram_cs = (region == REG_RAM);
  assign z22_cs = (region == REG_Z22);
  assign z23_cs = (region == REG_Z23);
  assign z24_cs = (region == REG_Z24);
  assign z25_cs = (region == REG_Z25);
  assign z26_cs = (region == REG_Z26);

  // One-hot I/O page select from addr[11:10]
  always_comb begin
    io_cs = 4'b0000;
    if (region == REG_IO) io_cs[addr[11:10]] = 1'b1;
  end

  aim65_ws_fsm #(
    .IO_WAIT (IO_WAIT)
  ) u_ws_fsm (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .io_acc  (region == REG_IO),
    .addr    (addr),
    .rdy     (rdy)
  );

  assign in_socket = (addr[15:12] == PAGE_Z26) || (addr[15:12] == PAGE_Z25);
  assign req_ok    = ({1'b0, sync_s2_q} < NUM_IMG_W);

  // Read-source register, selector synchroniser, image commit and sticky unmapped flag
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      sel_q        <= REG_NONE;
      iopg_q       <= 2'd0;
      img_q        <= '0;
      sync_s1_q    <= '0;
      sync_s2_q    <= '0;
      ext_active_q <= '0;
      unmapped_q   <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      iopg_q       <= iopg_d;
      img_q        <= img_d;
      sync_s1_q    <= sync_s1_d;
      sync_s2_q    <= sync_s2_d;
      ext_active_q <= ext_active_d;
      unmapped_q   <= unmapped_d;
    end
  end

  // Capture the source once the access completes; write cycles park the mux on open bus
  always_comb begin
    sel_d  = sel_q;
    iopg_d = iopg_q;
    img_d  = img_q;
    if (rdy) begin
      sel_d  = rw ? region : REG_NONE;
      iopg_d = addr[11:10];
      img_d  = ext_active_q;
    end
    sync_s1_d    = ext_selector;
    sync_s2_d    = sync_s1_q;
    ext_active_d = ext_active_q;
    // Only switch images at an opcode fetch outside the sockets, so no socket read is split
    if (sync && rdy && !in_socket && req_ok) ext_active_d = sync_s2_q;
    unmapped_d = unmapped_q | ((region == REG_NONE) && rdy);
  end

  // Read-data mux driven by the registered select (matches 1-cycle synchronous memories)
  always_comb begin
    cpu_data = OPEN_BUS;
    case (sel_q)
      REG_RAM: cpu_data = ram_do;
      REG_IO: begin
        case (iopg_q)
          2'd0:    cpu_data = io_do[7:0];
          2'd1:    cpu_data = io_do[15:8];
          2'd2:    cpu_data = io_do[23:16];
          default: cpu_data = io_do[31:24];
        endcase
      end
      REG_Z22: cpu_data = z22_do;
      REG_Z23: cpu_data = z23_do;
      REG_Z24: cpu_data = z24_do;
      REG_Z25: begin
        for (int i = 0; i < NUM_IMAGES; i++)
          if (img_q == SEL_W'(i)) cpu_data = z25_do[8*i +: 8];
      end
      REG_Z26: begin
        for (int i = 0; i < NUM_IMAGES; i++)
          if (img_q == SEL_W'(i)) cpu_data = z26_do[8*i +: 8];
      end
      default: cpu_data = OPEN_BUS;
    endcase
  end

  assign ext_active = ext_active_q;
  assign unmapped   = unmapped_q;

endmodule

// File: tb/tb_aim65_bus_ctrl.sv
// Scoreboard bench for aim65_bus_ctrl (IO_WAIT=2, three images per socket).
module tb_aim65_bus_ctrl;

  localparam int SEL_W = 2;
  localparam int NI    = 3;

  logic            cpu_clk = 1'b0;
  logic            reset;
  logic [15:0]     addr;
  logic            rw;
  logic            sync;
  logic [SEL_W-1:0] ext_selector;
  logic [7:0]      ram_do, z22_do, z23_do, z24_do;
  logic [8*NI-1:0] z25_do, z26_do;
  logic [31:0]     io_do;
  logic            ram_cs, z22_cs, z23_cs, z24_cs, z25_cs, z26_cs;
  logic [3:0]      io_cs;
  logic [7:0]      cpu_data;
  logic            rdy;
  logic [SEL_W-1:0] ext_active;
  logic            unmapped;

  logic            rd_chk;
  logic            pend = 1'b0;
  logic [7:0]      exp_q[$];
  int              checks = 0;
  int              errors = 0;
  int              w;

  aim65_bus_ctrl #(
    .RAM_AW(15), .NUM_IMAGES(NI), .SEL_W(SEL_W), .IO_WAIT(2), .OPEN_BUS(8'hFF)
  ) dut (
    .cpu_clk(cpu_clk), .reset(reset), .addr(addr), .rw(rw), .sync(sync),
    .ext_selector(ext_selector), .ram_do(ram_do), .z22_do(z22_do), .z23_do(z23_do),
    .z24_do(z24_do), .z25_do(z25_do), .z26_do(z26_do), .io_do(io_do),
    .ram_cs(ram_cs), .z22_cs(z22_cs), .z23_cs(z23_cs), .z24_cs(z24_cs),
    .z25_cs(z25_cs), .z26_cs(z26_cs), .io_cs(io_cs), .cpu_data(cpu_data),
    .rdy(rdy), .ext_active(ext_active), .unmapped(unmapped)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One CPU bus cycle, held until rdy; returns the number of rdy-low cycles seen
  task automatic bus(input logic [15:0] a, input logic r, input logic s,
                     input logic c, input logic [7:0] e, output int waits);
    @(posedge cpu_clk); #1;
    addr = a; rw = r; sync = s; rd_chk = c;
    if (c) exp_q.push_back(e);
    waits = 0;
    @(negedge cpu_clk);
    while (!rdy && waits < 20) begin
      waits++;
      @(negedge cpu_clk);
    end
    if (waits >= 20) begin
      checks++; errors++;
      $display("FAIL rdy_timeout: rdy still 0 after %0d cycles, expected release", waits);
    end
  endtask

  // Monitor: a read completed with rdy=1 presents its data on the next cycle
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge cpu_clk);
      if (pend) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: data %0h with no expected entry", cpu_data);
        end else begin
          e = exp_q.pop_front();
          if (cpu_data !== e) begin
            errors++;
            $display("FAIL read_data: got %0h expected %0h at %0t", cpu_data, e, $time);
          end
        end
      end
      pend = rd_chk && rw && rdy && !reset;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr = 16'h0010; rw = 1'b1; sync = 1'b0; rd_chk = 1'b0;
    ext_selector = '0;
    ram_do = 8'h5A; z22_do = 8'h22; z23_do = 8'h23; z24_do = 8'h24;
    z25_do = {8'hC2, 8'hC1, 8'hC0};
    z26_do = {8'hB2, 8'hB1, 8'hB0};
    io_do  = {8'hAC, 8'hA8, 8'hA4, 8'hA0};
    repeat (3) @(negedge cpu_clk);
    chk("reset_cpu_data", cpu_data, 8'hFF);
    chk("reset_rdy", rdy, 1);
    chk("reset_ext_active", ext_active, 0);
    chk("reset_unmapped", unmapped, 0);
    reset = 1'b0;

    // RAM read: no wait, data next cycle
    bus(16'h0010, 1'b1, 1'b0, 1'b1, 8'h5A, w);
    chk("ram_cs", ram_cs, 1);
    chk("ram_waits", w, 0);

    // I/O waits and re-arm rules
    bus(16'hA800, 1'b1, 1'b0, 1'b1, 8'hA8, w);
    chk("io_a800_waits", w, 2);
    chk("io_a800_cs", io_cs, 4'b0100);
    bus(16'hA800, 1'b1, 1'b0, 1'b1, 8'hA8, w);
    chk("io_held_no_rewait", w, 0);
    bus(16'h0010, 1'b1, 1'b0, 1'b1, 8'h5A, w);
    bus(16'hA000, 1'b1, 1'b0, 1'b1, 8'hA0, w);
    chk("io_a000_waits", w, 2);
    chk("io_a000_cs", io_cs, 4'b0001);
    bus(16'hA400, 1'b1, 1'b0, 1'b1, 8'hA4, w);
    chk("io_addr_change_waits", w, 2);
    chk("io_a400_cs", io_cs, 4'b0010);
    bus(16'hAC00, 1'b1, 1'b0, 1'b1, 8'hAC, w);
    chk("io_ac00_cs", io_cs, 4'b1000);

    // Image switch blocked inside the sockets, committed at the F000 fetch
    ext_selector = 2'd1;
    repeat (4) bus(16'hB004, 1'b1, 1'b1, 1'b1, 8'hB0, w);
    chk("z26_cs", z26_cs, 1);
    chk("ext_hold_in_socket", ext_active, 0);
    bus(16'hF000, 1'b1, 1'b1, 1'b1, 8'h22, w);
    chk("z22_cs", z22_cs, 1);
    bus(16'hC000, 1'b1, 1'b0, 1'b1, 8'hC1, w);
    chk("ext_commit_f000", ext_active, 1);
    chk("z25_cs", z25_cs, 1);

    // Out-of-range request ignored
    ext_selector = 2'd3;
    repeat (4) bus(16'hF000, 1'b1, 1'b1, 1'b1, 8'h22, w);
    chk("ext_ignore_3", ext_active, 1);
    ext_selector = 2'd2;
    repeat (3) bus(16'hF000, 1'b1, 1'b1, 1'b1, 8'h22, w);
    chk("ext_switch_2", ext_active, 2);
    bus(16'hB000, 1'b1, 1'b0, 1'b1, 8'hB2, w);
    bus(16'hD000, 1'b1, 1'b0, 1'b1, 8'h24, w);
    chk("z24_cs", z24_cs, 1);
    bus(16'hE000, 1'b1, 1'b0, 1'b1, 8'h23, w);
    chk("z23_cs", z23_cs, 1);
    chk("unmapped_before", unmapped, 0);

    // Unmapped read returns open bus and sets the sticky flag
    bus(16'h9000, 1'b1, 1'b0, 1'b1, 8'hFF, w);
    chk("unmapped_no_cs", {ram_cs, z22_cs, z23_cs, z24_cs, z25_cs, z26_cs, io_cs}, 0);
    bus(16'h0010, 1'b1, 1'b0, 1'b1, 8'h5A, w);
    chk("unmapped_set", unmapped, 1);
    repeat (3) bus(16'h0020, 1'b1, 1'b0, 1'b1, 8'h5A, w);
    chk("unmapped_sticky", unmapped, 1);

    // Reset in the middle of a wait
    @(posedge cpu_clk); #1;
    addr = 16'hA400; rw = 1'b1; sync = 1'b0; rd_chk = 1'b0;
    @(negedge cpu_clk);
    chk("wait_started", rdy, 0);
    @(posedge cpu_clk); #2;
    chk("still_waiting", rdy, 0);
    reset = 1'b1;
    #1;
    chk("reset_wait_rdy", rdy, 1);
    chk("reset_wait_ext", ext_active, 0);
    chk("reset_wait_data", cpu_data, 8'hFF);
    chk("reset_wait_unmapped", unmapped, 0);
    addr = 16'h0010;
    repeat (2) @(negedge cpu_clk);
    reset = 1'b0;
    bus(16'hA400, 1'b1, 1'b0, 1'b1, 8'hA4, w);
    chk("io_after_reset_waits", w, 2);
    bus(16'h0010, 1'b1, 1'b0, 1'b0, 8'h00, w);
    repeat (2) @(negedge cpu_clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
